floor_request_queue: RTL and testbench

Parametrised successor to the 8-floor call latch. It accepts raw per-floor call buttons, synchronises and debounces each one, and latches one pending request per floor. A request clears when the car reports arrival at that floor. The block also runs a direction state machine (IDLE/UP/DOWN) that publishes the next target floor to the elevator motion controller.

---
 rtl/floor_request_queue.sv | 144 ++++++++++++++
 tb/tb_floor_request_queue.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/floor_request_queue.sv
// Per-floor call latch with synchroniser, debounce and an IDLE/UP/DOWN
// direction machine that publishes the next floor to serve.
module floor_request_queue #(
  parameter int unsigned FLOORS   = 8,
  parameter int unsigned FW       = 3,
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FLOORS-1:0] sw,
  input  logic [FW-1:0]     floor,
  input  logic              arrive,
  output logic [FLOORS-1:0] swout,
  output logic [FW:0]       pending_count,
  output logic [1:0]        dir,
  output logic [FW-1:0]     target,
  output logic              target_valid
);

  localparam int unsigned CW   = 8;
  localparam int unsigned CNTW = FW + 1;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    UP   = 2'b01,
    DOWN = 2'b10
  } dir_e;

  logic [FLOORS-1:0] sync1_q, sync2_q;
  logic [FLOORS-1:0] deb_q, deb_d, deb_prev_q;
  logic [CW-1:0]     cnt_q [FLOORS];
  logic [CW-1:0]     cnt_d [FLOORS];
  logic [FLOORS-1:0] set_c;
  logic [FLOORS-1:0] swout_q, swout_d;
  dir_e              dir_q, dir_d;
  logic [FW-1:0]     target_q, target_d;
  logic              tv_q, tv_d;
  logic              above_c, below_c, found_c;

  // Debounce: count consecutive samples that disagree with the accepted level.
  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < FLOORS; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == CW'(DEBOUNCE - 1)) begin
          deb_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  assign set_c = deb_q & ~deb_prev_q;

  // Arrival clear has priority over a new press on the same floor.
  always_comb begin
    swout_d = swout_q;
    for (int i = 0; i < FLOORS; i++) begin
      if (arrive && (floor == FW'(i))) begin
        swout_d[i] = 1'b0;
      end else if (set_c[i]) begin
        swout_d[i] = 1'b1;
      end
    end
  end

  always_comb begin
    above_c = 1'b0;
    below_c = 1'b0;
    for (int i = 0; i < FLOORS; i++) begin
      if (swout_q[i] && (FW'(i) > floor)) above_c = 1'b1;
      if (swout_q[i] && (FW'(i) < floor)) below_c = 1'b1;
    end
  end

  // Direction next-state and target selection from the next direction.
  always_comb begin
    dir_d    = dir_q;
    target_d = '0;
    found_c  = 1'b0;
    tv_d     = |swout_q;
    case (dir_q)
      IDLE:    dir_d = above_c ? UP : (below_c ? DOWN : IDLE);
      UP:      dir_d = above_c ? UP : (below_c ? DOWN : IDLE);
      DOWN:    dir_d = below_c ? DOWN : (above_c ? UP : IDLE);
      default: dir_d = IDLE;
    endcase
    for (int i = 0; i < FLOORS; i++) begin
      case (dir_d)
        UP: begin
          if (!found_c && swout_q[i] && (FW'(i) > floor)) begin
            target_d = FW'(i);
            found_c  = 1'b1;
          end
        end
        DOWN: begin
          if (swout_q[i] && (FW'(i) < floor)) target_d = FW'(i);
        end
        default: begin
          if (swout_q[i] && (FW'(i) == floor)) target_d = floor;
        end
      endcase
    end
  end

  always_comb begin
    pending_count = '0;
    for (int i = 0; i < FLOORS; i++) begin
      pending_count = pending_count + CNTW'(swout_q[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      swout_q    <= '0;
      dir_q      <= IDLE;
      target_q   <= '0;
      tv_q       <= 1'b0;
      for (int i = 0; i < FLOORS; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q    <= sw;
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      swout_q    <= swout_d;
      dir_q      <= dir_d;
      target_q   <= target_d;
      tv_q       <= tv_d;
      for (int i = 0; i < FLOORS; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign swout        = swout_q;
  assign dir          = dir_q;
  assign target       = target_q;
  assign target_valid = tv_q;

endmodule

// File: tb/tb_floor_request_queue.sv
// Bench for floor_request_queue: 8-floor DUT checked every cycle against a
// sample-window model, plus a 10-floor DUT for out-of-range arrivals.
module tb_floor_request_queue;

  localparam int DEB = 4;

  logic       clk, rst;
  logic [7:0] sw;
  logic [2:0] floor;
  logic       arrive;
  logic [7:0] swout;
  logic [3:0] pending_count;
  logic [1:0] dir;
  logic [2:0] target;
  logic       target_valid;

  logic [9:0] sw10;
  logic [3:0] floor10;
  logic       arrive10;
  logic [9:0] swout10;
  logic [4:0] pc10;
  logic [1:0] dir10;
  logic [3:0] tgt10;
  logic       tv10;

  int checks = 0;
  int errors = 0;
  bit started = 0;

  floor_request_queue #(.FLOORS(8), .FW(3), .DEBOUNCE(DEB)) dut (
    .clk(clk), .rst(rst), .sw(sw), .floor(floor), .arrive(arrive),
    .swout(swout), .pending_count(pending_count), .dir(dir),
    .target(target), .target_valid(target_valid)
  );

  floor_request_queue #(.FLOORS(10), .FW(4), .DEBOUNCE(DEB)) dut10 (
    .clk(clk), .rst(rst), .sw(sw10), .floor(floor10), .arrive(arrive10),
    .swout(swout10), .pending_count(pc10), .dir(dir10),
    .target(tgt10), .target_valid(tv10)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a level is accepted once the last DEB synchronised samples
  // (raw samples two edges old) all disagree with the accepted level.
  logic [7:0] hist[$];
  logic [7:0] m_swout, m_acc, m_rose, n_swout, n_acc, n_rose, s;
  logic [1:0] m_dir, n_dir;
  logic [2:0] m_tgt, n_tgt;
  logic       m_tv;
  bit         flip;

  function automatic logic [1:0] f_dir(input logic [1:0] cur, input logic [7:0] p, input logic [2:0] f);
    bit ab = 0, be = 0;
    for (int i = 0; i < 8; i++) begin
      if (p[i] && i > int'(f)) ab = 1;
      if (p[i] && i < int'(f)) be = 1;
    end
    if (cur == 2'b10) return be ? 2'b10 : (ab ? 2'b01 : 2'b00);
    return ab ? 2'b01 : (be ? 2'b10 : 2'b00);
  endfunction

  function automatic logic [2:0] f_tgt(input logic [1:0] d, input logic [7:0] p, input logic [2:0] f);
    if (d == 2'b01) begin
      for (int i = 0; i < 8; i++) if (p[i] && i > int'(f)) return 3'(i);
    end else if (d == 2'b10) begin
      for (int i = 7; i >= 0; i--) if (p[i] && i < int'(f)) return 3'(i);
    end else if (p[f]) begin
      return f;
    end
    return 3'd0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_swout = '0; m_acc = '0; m_rose = '0;
      m_dir = '0; m_tgt = '0; m_tv = 1'b0;
      hist.delete();
    end else begin
      n_swout = m_swout;
      for (int i = 0; i < 8; i++) begin
        if (arrive && floor == 3'(i)) n_swout[i] = 1'b0;
        else if (m_rose[i]) n_swout[i] = 1'b1;
      end
      n_acc  = m_acc;
      n_rose = '0;
      for (int i = 0; i < 8; i++) begin
        flip = 1;
        for (int j = 1; j <= DEB; j++) begin
          s = (hist.size() > j) ? hist[j] : 8'h00;
          if (s[i] == m_acc[i]) flip = 0;
        end
        if (flip) begin
          n_acc[i]  = ~m_acc[i];
          n_rose[i] = n_acc[i];
        end
      end
      n_dir = f_dir(m_dir, m_swout, floor);
      n_tgt = f_tgt(n_dir, m_swout, floor);
      m_tv  = |m_swout;
      m_swout = n_swout; m_acc = n_acc; m_rose = n_rose;
      m_dir = n_dir; m_tgt = n_tgt;
      hist.push_front(sw);
      if (hist.size() > 16) void'(hist.pop_back());
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("m_swout", 32'(swout), 32'(m_swout));
      chk("m_count", 32'(pending_count), $countones(m_swout));
      chk("m_dir", 32'(dir), 32'(m_dir));
      chk("m_target", 32'(target), 32'(m_tgt));
      chk("m_tvalid", 32'(target_valid), 32'(m_tv));
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    sw = '0;
    step(2);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0; sw = 8'hFF; floor = '0; arrive = 1'b0;
    sw10 = '0; floor10 = '0; arrive10 = 1'b0;
    #2 rst = 1'b1;
    #1 started = 1;

    // All buttons held through reset; all set together 7 edges after release.
    step(3);
    chk("rst_swout", 32'(swout), 0);
    chk("rst_count", 32'(pending_count), 0);
    chk("rst_dir", 32'(dir), 0);
    chk("rst_target", 32'(target), 0);
    chk("rst_tvalid", 32'(target_valid), 0);
    rst = 1'b0;
    step(6);
    chk("all_edge6", 32'(swout), 0);
    step(1);
    chk("all_swout", 32'(swout), 32'hFF);
    chk("all_count", 32'(pending_count), 8);
    do_reset();

    // Reset mid-debounce, button still held: full latency again.
    sw = 8'h20;
    step(4);
    #2 rst = 1'b1;
    #1 chk("midrst_swout", 32'(swout), 0);
    step(2);
    rst = 1'b0;
    step(6);
    chk("midrst_edge6", 32'(swout), 0);
    step(1);
    chk("midrst_edge7", 32'(swout), 32'h20);
    do_reset();

    // Single call above the car, then arrival there.
    sw = 8'h40; floor = 3'd0;
    step(6);
    chk("f6_edge6", 32'(swout), 0);
    step(1);
    chk("f6_swout", 32'(swout), 32'h40);
    step(1);
    chk("f6_dir", 32'(dir), 1);
    chk("f6_target", 32'(target), 6);
    chk("f6_tvalid", 32'(target_valid), 1);
    step(12);
    sw = '0; floor = 3'd6; arrive = 1'b1;
    step(1);
    arrive = 1'b0;
    chk("f6_clear", 32'(swout), 0);
    step(1);
    chk("f6_idle", 32'(dir), 0);
    chk("f6_tv0", 32'(target_valid), 0);
    chk("f6_tgt0", 32'(target), 0);

    // Three-cycle glitch is rejected.
    sw = 8'h08;
    step(3);
    sw = '0;
    step(10);
    chk("glitch", 32'(swout), 0);

    // Calls at 1, 5, 7 with the car at 4.
    floor = 3'd4; sw = 8'hA2;
    step(7);
    chk("sweep_swout", 32'(swout), 32'hA2);
    sw = '0;
    step(1);
    chk("sweep_dir_up", 32'(dir), 1);
    chk("sweep_t5", 32'(target), 5);
    floor = 3'd5; arrive = 1'b1;
    step(1);
    arrive = 1'b0;
    chk("sweep_arr5", 32'(swout), 32'h82);
    step(1);
    chk("sweep_t7", 32'(target), 7);
    chk("sweep_up2", 32'(dir), 1);
    floor = 3'd7; arrive = 1'b1;
    step(1);
    arrive = 1'b0;
    chk("sweep_arr7", 32'(swout), 32'h02);
    step(1);
    chk("sweep_down", 32'(dir), 2);
    chk("sweep_t1", 32'(target), 1);
    floor = 3'd1; arrive = 1'b1;
    step(1);
    arrive = 1'b0;
    step(2);

    // Set pulse for floor 2 coincides with arrival at floor 2.
    floor = 3'd2; sw = 8'h04;
    step(6);
    arrive = 1'b1;
    step(1);
    arrive = 1'b0;
    chk("clr_beats_set", 32'(swout), 0);
    step(3);
    chk("clr_beats_set2", 32'(swout), 0);
    sw = '0;
    step(2);

    // Ten-floor build: top floor clears, out-of-range floor is ignored.
    sw10 = 10'h201;
    step(7);
    chk("f10_swout", 32'(swout10), 32'h201);
    chk("f10_count", 32'(pc10), 2);
    step(1);
    chk("f10_dir", 32'(dir10), 1);
    chk("f10_target", 32'(tgt10), 9);
    chk("f10_tvalid", 32'(tv10), 1);
    sw10 = '0; floor10 = 4'd12; arrive10 = 1'b1;
    step(1);
    arrive10 = 1'b0;
    chk("f10_oor", 32'(swout10), 32'h201);
    floor10 = 4'd9; arrive10 = 1'b1;
    step(1);
    arrive10 = 1'b0;
    chk("f10_arr9", 32'(swout10), 32'h001);
    chk("f10_count1", 32'(pc10), 1);
    step(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
